// File: rtl/lm80c_ps2_matrix.sv
// PS/2 keyboard receiver and scancode decoder that drives the LM80C 8x8 active-low key matrix.
// The receive FSM state is exported on rx_state (IDLE=0, DATA=1, PARITY=2, STOP=3).
module lm80c_ps2_matrix #(
  parameter int FILTER_LEN     = 8,
  parameter int TIMEOUT_CYCLES = 100000
) (
  input  logic            sys_clock,
  input  logic            RESET,
  input  logic            ps2_clk,
  input  logic            ps2_data,
  output logic [7:0][7:0] KM,
  output logic [7:0]      scancode,
  output logic            scancode_valid,
  output logic            frame_error,
  output logic [1:0]      rx_state
);

  localparam int FW = $clog2(FILTER_LEN + 1);
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [FW-1:0] FILT_LAST = FW'(FILTER_LEN - 1);
  localparam logic [TW-1:0] TMO_LAST  = TW'(TIMEOUT_CYCLES - 1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DATA   = 2'd1,
    PARITY = 2'd2,
    STOP   = 2'd3
  } rx_state_t;

  rx_state_t      state, state_next;
  logic [1:0]     clk_sync, data_sync;
  logic           clk_filt;
  logic [FW-1:0]  filt_cnt;
  logic           fall_evt;
  logic           data_bit;
  logic [2:0]     bit_cnt;
  logic [7:0]     shift_q;
  logic           parity_q;
  logic [TW-1:0]  tmo_cnt;
  logic           timeout;
  logic           frame_ok, frame_bad;
  logic           ext, brk;
  logic [2:0]     skip;
  logic [6:0]     map_entry;
  logic           map_hit;
  logic [2:0]     map_row, map_col;

  assign rx_state = state;
  assign data_bit = data_sync[1];

  // Idle PS/2 lines are high, so the synchronisers reset to 1.
  always_ff @(posedge sys_clock) begin
    if (RESET) begin
      clk_sync  <= 2'b11;
      data_sync <= 2'b11;
    end else begin
      clk_sync  <= {clk_sync[0], ps2_clk};
      data_sync <= {data_sync[0], ps2_data};
    end
  end

  // The filtered clock flips on the FILTER_LEN-th consecutive differing sample.
  always_ff @(posedge sys_clock) begin
    if (RESET) begin
      clk_filt <= 1'b1;
      filt_cnt <= '0;
    end else if (clk_sync[1] != clk_filt) begin
      if (filt_cnt == FILT_LAST) begin
        clk_filt <= clk_sync[1];
        filt_cnt <= '0;
      end else begin
        filt_cnt <= filt_cnt + 1'b1;
      end
    end else begin
      filt_cnt <= '0;
    end
  end

  assign fall_evt = clk_filt && !clk_sync[1] && (filt_cnt == FILT_LAST);
  assign timeout  = (state != IDLE) && (tmo_cnt == TMO_LAST);

  always_ff @(posedge sys_clock) begin
    if (RESET) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // A sampling event in the same cycle as the timeout restarts the bit window instead.
  always_comb begin
    state_next = state;
    frame_ok   = 1'b0;
    frame_bad  = 1'b0;
    if (fall_evt) begin
      unique case (state)
        IDLE:   if (!data_bit) state_next = DATA;
        DATA:   if (bit_cnt == 3'd7) state_next = PARITY;
        PARITY: state_next = STOP;
        STOP: begin
          if (data_bit && (^{shift_q, parity_q})) frame_ok = 1'b1;
          else frame_bad = 1'b1;
          state_next = IDLE;
        end
        default: state_next = IDLE;
      endcase
    end else if (timeout) begin
      state_next = IDLE;
      frame_bad  = 1'b1;
    end
  end

  always_ff @(posedge sys_clock) begin
    if (RESET) begin
      bit_cnt  <= '0;
      shift_q  <= '0;
      parity_q <= 1'b0;
      tmo_cnt  <= '0;
    end else begin
      if (state == IDLE || fall_evt) tmo_cnt <= '0;
      else tmo_cnt <= tmo_cnt + 1'b1;
      if (fall_evt) begin
        case (state)
          IDLE:   bit_cnt <= '0;
          DATA: begin
            shift_q <= {data_bit, shift_q[7:1]};
            bit_cnt <= bit_cnt + 3'd1;
          end
          PARITY: parity_q <= data_bit;
          default: ;
        endcase
      end
    end
  end

  always_ff @(posedge sys_clock) begin
    if (RESET) begin
      scancode       <= '0;
      scancode_valid <= 1'b0;
      frame_error    <= 1'b0;
    end else begin
      scancode_valid <= frame_ok;
      frame_error    <= frame_bad;
      if (frame_ok) scancode <= shift_q;
    end
  end

  // Keymap ROM: {ext, byte} -> {hit, row, col}.
  function automatic logic [6:0] keymap(input logic [8:0] key);
    keymap = '0;
    case (key)
      9'h066: keymap = {1'b1, 3'd0, 3'd0};
      9'h005: keymap = {1'b1, 3'd0, 3'd1};
      9'h006: keymap = {1'b1, 3'd0, 3'd2};
      9'h175: keymap = {1'b1, 3'd0, 3'd3};
      9'h004: keymap = {1'b1, 3'd0, 3'd4};
      9'h172: keymap = {1'b1, 3'd0, 3'd5};
      9'h174: keymap = {1'b1, 3'd0, 3'd6};
      9'h05A: keymap = {1'b1, 3'd0, 3'd7};
      9'h01C: keymap = {1'b1, 3'd1, 3'd0};
      9'h01B: keymap = {1'b1, 3'd1, 3'd1};
      9'h023: keymap = {1'b1, 3'd1, 3'd2};
      9'h02B: keymap = {1'b1, 3'd1, 3'd3};
      9'h034: keymap = {1'b1, 3'd1, 3'd4};
      9'h033: keymap = {1'b1, 3'd1, 3'd5};
      9'h03B: keymap = {1'b1, 3'd1, 3'd6};
      9'h042: keymap = {1'b1, 3'd1, 3'd7};
      9'h015: keymap = {1'b1, 3'd2, 3'd0};
      9'h01D: keymap = {1'b1, 3'd2, 3'd1};
      9'h024: keymap = {1'b1, 3'd2, 3'd2};
      9'h02D: keymap = {1'b1, 3'd2, 3'd3};
      9'h02C: keymap = {1'b1, 3'd2, 3'd4};
      9'h035: keymap = {1'b1, 3'd2, 3'd5};
      9'h03C: keymap = {1'b1, 3'd2, 3'd6};
      9'h043: keymap = {1'b1, 3'd2, 3'd7};
      9'h016: keymap = {1'b1, 3'd3, 3'd0};
      9'h01E: keymap = {1'b1, 3'd3, 3'd1};
      9'h026: keymap = {1'b1, 3'd3, 3'd2};
      9'h025: keymap = {1'b1, 3'd3, 3'd3};
      9'h02E: keymap = {1'b1, 3'd3, 3'd4};
      9'h036: keymap = {1'b1, 3'd3, 3'd5};
      9'h03D: keymap = {1'b1, 3'd3, 3'd6};
      9'h03E: keymap = {1'b1, 3'd3, 3'd7};
      9'h01A: keymap = {1'b1, 3'd4, 3'd0};
      9'h022: keymap = {1'b1, 3'd4, 3'd1};
      9'h021: keymap = {1'b1, 3'd4, 3'd2};
      9'h02A: keymap = {1'b1, 3'd4, 3'd3};
      9'h032: keymap = {1'b1, 3'd4, 3'd4};
      9'h031: keymap = {1'b1, 3'd4, 3'd5};
      9'h03A: keymap = {1'b1, 3'd4, 3'd6};
      9'h041: keymap = {1'b1, 3'd4, 3'd7};
      9'h044: keymap = {1'b1, 3'd5, 3'd0};
      9'h04D: keymap = {1'b1, 3'd5, 3'd1};
      9'h04B: keymap = {1'b1, 3'd5, 3'd2};
      9'h04C: keymap = {1'b1, 3'd5, 3'd3};
      9'h052: keymap = {1'b1, 3'd5, 3'd4};
      9'h049: keymap = {1'b1, 3'd5, 3'd5};
      9'h04A: keymap = {1'b1, 3'd5, 3'd6};
      9'h046: keymap = {1'b1, 3'd5, 3'd7};
      9'h012: keymap = {1'b1, 3'd6, 3'd0};
      9'h059: keymap = {1'b1, 3'd6, 3'd1};
      9'h014: keymap = {1'b1, 3'd6, 3'd2};
      9'h011: keymap = {1'b1, 3'd6, 3'd3};
      9'h045: keymap = {1'b1, 3'd6, 3'd4};
      9'h04E: keymap = {1'b1, 3'd6, 3'd5};
      9'h055: keymap = {1'b1, 3'd6, 3'd6};
      9'h00E: keymap = {1'b1, 3'd6, 3'd7};
      9'h076: keymap = {1'b1, 3'd7, 3'd0};
      9'h054: keymap = {1'b1, 3'd7, 3'd1};
      9'h05B: keymap = {1'b1, 3'd7, 3'd2};
      9'h05D: keymap = {1'b1, 3'd7, 3'd3};
      9'h029: keymap = {1'b1, 3'd7, 3'd4};
      9'h058: keymap = {1'b1, 3'd7, 3'd5};
      9'h00D: keymap = {1'b1, 3'd7, 3'd6};
      9'h171: keymap = {1'b1, 3'd7, 3'd7};
      default: keymap = '0;
    endcase
  endfunction

  assign map_entry = keymap({ext, scancode});
  assign map_hit   = map_entry[6];
  assign map_row   = map_entry[5:3];
  assign map_col   = map_entry[2:0];

  // Skipped bytes (the tail of the Pause sequence) take precedence over every prefix.
  always_ff @(posedge sys_clock) begin
    if (RESET) begin
      KM   <= '1;
      ext  <= 1'b0;
      brk  <= 1'b0;
      skip <= '0;
    end else if (scancode_valid) begin
      if (skip != 3'd0) begin
        skip <= skip - 3'd1;
      end else begin
        case (scancode)
          8'hE1: begin
            skip <= 3'd7;
            ext  <= 1'b0;
            brk  <= 1'b0;
          end
          8'hE0: ext <= 1'b1;
          8'hF0: brk <= 1'b1;
          8'hAA: begin
            KM  <= '1;
            ext <= 1'b0;
            brk <= 1'b0;
          end
          8'hFA, 8'hEE, 8'hFC, 8'h00, 8'hFF: begin
            ext <= 1'b0;
            brk <= 1'b0;
          end
          default: begin
            if (map_hit) KM[map_row][map_col] <= brk;
            ext <= 1'b0;
            brk <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_lm80c_ps2_matrix.sv
// Directed bench for lm80c_ps2_matrix: table of PS/2 frames with expected matrix rows, plus
// hand sequences for latency, timeout, glitch filtering, self-test reset and mid-frame RESET.
module tb_lm80c_ps2_matrix;

  localparam int TMO = 2000;

  logic            sys_clock = 1'b0;
  logic            RESET;
  logic            ps2_clk;
  logic            ps2_data;
  logic [7:0][7:0] KM;
  logic [7:0]      scancode;
  logic            scancode_valid;
  logic            frame_error;
  logic [1:0]      rx_state;

  int n_checks = 0;
  int n_errors = 0;
  int n_valid  = 0;
  int n_err    = 0;

  typedef struct {
    logic [7:0] code;
    logic [1:0] kind;   // 0 good frame, 1 flipped parity, 2 stop bit 0
    logic [2:0] row;
    logic [7:0] exp_row;
  } vec_t;

  vec_t vecs[31];
  logic [7:0] exp_code;

  lm80c_ps2_matrix #(.FILTER_LEN(8), .TIMEOUT_CYCLES(TMO)) dut (
    .sys_clock      (sys_clock),
    .RESET          (RESET),
    .ps2_clk        (ps2_clk),
    .ps2_data       (ps2_data),
    .KM             (KM),
    .scancode       (scancode),
    .scancode_valid (scancode_valid),
    .frame_error    (frame_error),
    .rx_state       (rx_state)
  );

  // Clock and watchdog
  always #5 sys_clock = ~sys_clock;

  initial begin
    #3ms;
    $display("FAIL watchdog: got no end of test, expected finish before 3ms");
    $fatal(1, "watchdog");
  end

  // Pulse monitor, sampled just after the active edge
  always @(posedge sys_clock) begin
    #1;
    if (scancode_valid) n_valid++;
    if (frame_error) n_err++;
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [10:0] make_frame(input logic [7:0] b, input logic [1:0] kind);
    logic par;
    logic stp;
    par = ~(^b) ^ (kind == 2'd1);
    stp = (kind != 2'd2);
    return {stp, par, b, 1'b0};
  endfunction

  // Driver: bits first..last of a frame, LSB (start bit) first
  task automatic send_bits(input logic [10:0] fr, input int first, input int last);
    for (int i = first; i <= last; i++) begin
      ps2_data = fr[i];
      repeat (10) @(negedge sys_clock);
      ps2_clk = 1'b0;
      repeat (20) @(negedge sys_clock);
      ps2_clk = 1'b1;
      repeat (10) @(negedge sys_clock);
    end
  endtask

  task automatic send_byte(input logic [7:0] b);
    send_bits(make_frame(b, 2'd0), 0, 10);
    repeat (5) @(negedge sys_clock);
  endtask

  task automatic glitch(input int n);
    for (int i = 0; i < n; i++) begin
      ps2_clk = 1'b0;
      repeat (3) @(negedge sys_clock);
      ps2_clk = 1'b1;
      repeat (10) @(negedge sys_clock);
    end
  endtask

  task automatic set_vec(input int i, input logic [7:0] c, input logic [1:0] k,
                         input logic [2:0] r, input logic [7:0] e);
    vecs[i].code    = c;
    vecs[i].kind    = k;
    vecs[i].row     = r;
    vecs[i].exp_row = e;
  endtask

  initial begin
    int v0, e0;
    logic found;
    logic [10:0] fr;

    set_vec(0,  8'hF0, 2'd0, 3'd1, 8'hFE);
    set_vec(1,  8'h1C, 2'd0, 3'd1, 8'hFF);
    set_vec(2,  8'h12, 2'd0, 3'd6, 8'hFE);
    set_vec(3,  8'h29, 2'd0, 3'd7, 8'hEF);
    set_vec(4,  8'hF0, 2'd0, 3'd7, 8'hEF);
    set_vec(5,  8'h12, 2'd0, 3'd6, 8'hFF);
    set_vec(6,  8'hE0, 2'd0, 3'd7, 8'hEF);
    set_vec(7,  8'h75, 2'd0, 3'd0, 8'hF7);
    set_vec(8,  8'h75, 2'd0, 3'd0, 8'hF7);
    set_vec(9,  8'hE0, 2'd0, 3'd0, 8'hF7);
    set_vec(10, 8'hF0, 2'd0, 3'd0, 8'hF7);
    set_vec(11, 8'h75, 2'd0, 3'd0, 8'hFF);
    set_vec(12, 8'h1C, 2'd1, 3'd1, 8'hFF);
    set_vec(13, 8'h1C, 2'd2, 3'd1, 8'hFF);
    set_vec(14, 8'h5A, 2'd0, 3'd0, 8'h7F);
    set_vec(15, 8'hE1, 2'd0, 3'd0, 8'h7F);
    set_vec(16, 8'h14, 2'd0, 3'd6, 8'hFF);
    set_vec(17, 8'h77, 2'd0, 3'd6, 8'hFF);
    set_vec(18, 8'hE1, 2'd0, 3'd6, 8'hFF);
    set_vec(19, 8'hF0, 2'd0, 3'd6, 8'hFF);
    set_vec(20, 8'h14, 2'd0, 3'd6, 8'hFF);
    set_vec(21, 8'hF0, 2'd0, 3'd6, 8'hFF);
    set_vec(22, 8'h77, 2'd0, 3'd6, 8'hFF);
    set_vec(23, 8'h14, 2'd0, 3'd6, 8'hFB);
    set_vec(24, 8'hF0, 2'd0, 3'd6, 8'hFB);
    set_vec(25, 8'h14, 2'd0, 3'd6, 8'hFF);
    set_vec(26, 8'hE0, 2'd0, 3'd0, 8'h7F);
    set_vec(27, 8'hFA, 2'd0, 3'd0, 8'h7F);
    set_vec(28, 8'h75, 2'd0, 3'd0, 8'h7F);
    set_vec(29, 8'hF0, 2'd0, 3'd0, 8'h7F);
    set_vec(30, 8'h5A, 2'd0, 3'd0, 8'hFF);

    // Reset state
    RESET    = 1'b1;
    ps2_clk  = 1'b1;
    ps2_data = 1'b1;
    repeat (5) @(negedge sys_clock);
    check("reset_km", KM, {64{1'b1}});
    check("reset_scancode", scancode, 8'h00);
    check("reset_valid", scancode_valid, 1'b0);
    check("reset_ferr", frame_error, 1'b0);
    check("reset_state", rx_state, 2'd0);
    RESET = 1'b0;
    repeat (5) @(negedge sys_clock);

    // 1C press: scancode_valid for one cycle, KM[1] changes one cycle later
    fr = make_frame(8'h1C, 2'd0);
    send_bits(fr, 0, 9);
    ps2_data = 1'b1;
    repeat (10) @(negedge sys_clock);
    ps2_clk = 1'b0;
    found = 1'b0;
    for (int k = 0; k < 100 && !found; k++) begin
      @(negedge sys_clock);
      if (scancode_valid) found = 1'b1;
    end
    check("lat_valid_seen", found, 1'b1);
    if (found) begin
      check("lat_scancode", scancode, 8'h1C);
      check("lat_km_before", KM[1], 8'hFF);
      @(negedge sys_clock);
      check("lat_valid_pulse", scancode_valid, 1'b0);
      check("lat_km_after", KM[1], 8'hFE);
    end
    repeat (20) @(negedge sys_clock);
    ps2_clk = 1'b1;
    repeat (10) @(negedge sys_clock);
    exp_code = 8'h1C;

    // Table-driven frames
    for (int i = 0; i < 31; i++) begin
      v0 = n_valid;
      e0 = n_err;
      send_bits(make_frame(vecs[i].code, vecs[i].kind), 0, 10);
      repeat (5) @(negedge sys_clock);
      if (vecs[i].kind == 2'd0) exp_code = vecs[i].code;
      check($sformatf("vec%0d_valid", i), 64'(n_valid - v0), (vecs[i].kind == 2'd0) ? 64'd1 : 64'd0);
      check($sformatf("vec%0d_ferr", i), 64'(n_err - e0), (vecs[i].kind == 2'd0) ? 64'd0 : 64'd1);
      check($sformatf("vec%0d_scancode", i), scancode, exp_code);
      check($sformatf("vec%0d_km_row%0d", i, vecs[i].row), KM[vecs[i].row], vecs[i].exp_row);
    end
    check("held_space", KM[7], 8'hEF);

    // Timeout after 4 data bits
    e0 = n_err;
    send_bits(make_frame(8'h1C, 2'd0), 0, 4);
    check("tmo_state_data", rx_state, 2'd1);
    repeat (TMO - 300) @(negedge sys_clock);
    check("tmo_not_early", 64'(n_err - e0), 64'd0);
    for (int k = 0; k < 600 && n_err == e0; k++) @(negedge sys_clock);
    check("tmo_ferr", 64'(n_err - e0), 64'd1);
    check("tmo_state_idle", rx_state, 2'd0);
    send_byte(8'h1C);
    check("tmo_next_scancode", scancode, 8'h1C);
    check("tmo_next_km1", KM[1], 8'hFE);

    // Glitches shorter than the filter
    v0 = n_valid;
    e0 = n_err;
    ps2_data = 1'b0;
    glitch(5);
    check("glitch_idle_state", rx_state, 2'd0);
    fr = make_frame(8'h29, 2'd0);
    send_bits(fr, 0, 3);
    glitch(3);
    check("glitch_data_state", rx_state, 2'd1);
    send_bits(fr, 4, 10);
    repeat (5) @(negedge sys_clock);
    check("glitch_scancode", scancode, 8'h29);
    check("glitch_valid_cnt", 64'(n_valid - v0), 64'd1);
    check("glitch_ferr_cnt", 64'(n_err - e0), 64'd0);

    // Self-test pass clears every held key
    check("aa_pre_km1", KM[1], 8'hFE);
    send_byte(8'hAA);
    for (int r = 0; r < 8; r++) check($sformatf("aa_row%0d", r), KM[r], 8'hFF);

    // RESET mid-frame discards the partial byte
    send_byte(8'h5A);
    check("rst_pre_km0", KM[0], 8'h7F);
    send_bits(make_frame(8'h1C, 2'd0), 0, 5);
    RESET = 1'b1;
    @(negedge sys_clock);
    check("rst_km", KM, {64{1'b1}});
    check("rst_scancode", scancode, 8'h00);
    check("rst_valid", scancode_valid, 1'b0);
    check("rst_ferr", frame_error, 1'b0);
    check("rst_state", rx_state, 2'd0);
    RESET = 1'b0;
    repeat (5) @(negedge sys_clock);
    v0 = n_valid;
    send_byte(8'h1C);
    check("rst_next_valid_cnt", 64'(n_valid - v0), 64'd1);
    check("rst_next_scancode", scancode, 8'h1C);
    check("rst_next_km1", KM[1], 8'hFE);
    check("rst_next_km0", KM[0], 8'hFF);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
